// File: rtl/gcd_arbiter_if.sv
// Requester, response and shared-engine signals of the GCD arbiter.
// slave = arbiter view; master = requesters plus the engine.
interface gcd_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       gnt;
  logic [N_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]       rsp_result;
  logic                   eng_start;
  logic [WIDTH-1:0]       eng_a;
  logic [WIDTH-1:0]       eng_b;
  logic [WIDTH-1:0]       eng_result;
  logic                   eng_done;
  logic                   busy;

  modport slave (
    input  req, req_a, req_b, eng_result, eng_done,
    output gnt, rsp_valid, rsp_result, eng_start, eng_a, eng_b, busy
  );

  modport master (
    output req, req_a, req_b, eng_result, eng_done,
    input  gnt, rsp_valid, rsp_result, eng_start, eng_a, eng_b, busy
  );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one GCD engine among N_REQ requesters.
// Zero operands bypass the engine; gnt and rsp_valid are registered one-cycle pulses.
module gcd_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  gcd_arbiter_if.slave bus
);
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;

  logic [IDX_W-1:0] cand [N_REQ];
  logic             found;
  logic [IDX_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // cand[k] is the k-th index visited when searching upward from ptr
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    assign cand[gi] = IDX_W'((int'(ptr_q) + gi) % N_REQ);
  end

  // Descending scan so the smallest offset from ptr wins
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req[cand[k]]) begin
        found   = 1'b1;
        sel_idx = cand[k];
      end
    end
  end

  assign sel_a = bus.req_a[int'(sel_idx)*WIDTH +: WIDTH];
  assign sel_b = bus.req_b[int'(sel_idx)*WIDTH +: WIDTH];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    idx_d        = idx_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    rsp_result_d = rsp_result_q;
    gnt_d        = '0;
    rsp_valid_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          idx_d = sel_idx;
          a_d   = sel_a;
          b_d   = sel_b;
          gnt_d = onehot(sel_idx);
          // A zero operand would never terminate a Euclid engine
          if ((sel_a == '0) || (sel_b == '0)) begin
            result_d = (sel_a == '0) ? sel_b : sel_a;
            state_d  = ST_RESP;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.eng_done) begin
          result_d = bus.eng_result;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid_d  = onehot(idx_q);
        rsp_result_d = result_q;
        ptr_d        = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      idx_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      result_q     <= '0;
      rsp_result_q <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      idx_q        <= idx_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
      rsp_result_q <= rsp_result_d;
      gnt_q        <= gnt_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.eng_start  = (state_q == ST_ISSUE);
  assign bus.eng_a      = a_q;
  assign bus.eng_b      = b_q;
  assign bus.busy       = (state_q != ST_IDLE);
endmodule

// File: tb/tb_gcd_arbiter.sv
// Bench for gcd_arbiter: Euclid engine model, transaction-level reference,
// per-cycle output compare, directed scenarios and randomized requesters.
module tb_gcd_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   n_rsp  = 0;

  always #5 clk = ~clk;

  gcd_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  gcd_arbiter #(.N_REQ(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a, y = b, t;
    while (y != '0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // Cycles the bench engine needs from accepting start to raising done
  function automatic int eng_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] x = a, y = b, t;
    int s = 0;
    while (y != '0) begin t = x % y; x = y; y = t; s++; end
    return s + 1;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  function automatic logic [W-1:0] op_of(input logic [N*W-1:0] v, input int i);
    return v[i*W +: W];
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  function automatic logic [W-1:0] rand_op();
    int r = $urandom_range(0, 9);
    if (r == 0) return '0;
    if (r == 1) return $urandom();
    return W'($urandom_range(1, 200));
  endfunction

  // Shared engine: one Euclid step per cycle, done is a level cleared by start
  logic [W-1:0] ex, ey;
  logic         erun;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ex <= '0; ey <= '0; erun <= 1'b0;
      bus.eng_done <= 1'b0; bus.eng_result <= '0;
    end else if (bus.eng_start) begin
      ex <= bus.eng_a; ey <= bus.eng_b; erun <= 1'b1; bus.eng_done <= 1'b0;
    end else if (erun) begin
      if (ey == '0) begin
        bus.eng_result <= ex; bus.eng_done <= 1'b1; erun <= 1'b0;
      end else begin
        ex <= ey; ey <= ex % ey;
      end
    end
  end

  // Reference: one operation at a time, timed by selection edge and response edge
  int           edge_cnt   = 0;
  bit           m_active   = 1'b0;
  bit           m_bypass   = 1'b0;
  int           m_ptr      = 0;
  int           m_idx      = 0;
  int           m_sel_edge = 0;
  int           m_rsp_edge = 0;
  logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
  int           pick_c;
  logic [W-1:0] pa_c, pb_c;

  always_comb begin
    pick_c = rr_pick(bus.req, m_ptr);
    pa_c   = op_of(bus.req_a, pick_c);
    pb_c   = op_of(bus.req_b, pick_c);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0; m_ptr <= 0; m_a <= '0; m_b <= '0;
    end else begin
      edge_cnt <= edge_cnt + 1;
      if ((!m_active || (edge_cnt + 1 > m_rsp_edge)) && (bus.req != '0)) begin
        m_active   <= 1'b1;
        m_idx      <= pick_c;
        m_ptr      <= (pick_c + 1) % N;
        m_a        <= pa_c;
        m_b        <= pb_c;
        m_res      <= gcd_ref(pa_c, pb_c);
        m_bypass   <= (pa_c == '0) || (pb_c == '0);
        m_sel_edge <= edge_cnt + 1;
        m_rsp_edge <= edge_cnt + 1 +
                      (((pa_c == '0) || (pb_c == '0)) ? 1 : 3 + eng_lat(pa_c, pb_c));
      end
    end
  end

  always @(negedge clk) begin
    chk("gnt", bus.gnt, (m_active && edge_cnt == m_sel_edge) ? onehot(m_idx) : '0);
    chk("rsp_valid", bus.rsp_valid, (m_active && edge_cnt == m_rsp_edge) ? onehot(m_idx) : '0);
    chk("eng_start", bus.eng_start, m_active && !m_bypass && edge_cnt == m_sel_edge);
    chk("busy", bus.busy, m_active && edge_cnt >= m_sel_edge && edge_cnt < m_rsp_edge);
    chk("eng_a", bus.eng_a, m_a);
    chk("eng_b", bus.eng_b, m_b);
    if (m_active && edge_cnt == m_rsp_edge) begin
      chk("rsp_result", bus.rsp_result, m_res);
      n_rsp++;
      $display("rsp idx=%0d result=%0d t=%0t", m_idx, bus.rsp_result, $time);
    end
    if (rst) chk("rsp_result_rst", bus.rsp_result, '0);
  end

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic run_single(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                            input bit perturb, output logic [W-1:0] res,
                            output logic [N-1:0] rv, output int lat,
                            output int starts, output int gnts);
    int g_at = -1;
    res = '0; rv = '0; lat = -1; starts = 0; gnts = 0;
    @(negedge clk);
    set_op(i, a, b);
    bus.req[i] = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (bus.eng_start) starts++;
      if (bus.gnt != '0) begin
        gnts++;
        if (bus.gnt[i]) begin bus.req[i] = 1'b0; g_at = n; end
      end else if (perturb && bus.busy) begin
        set_op(i, $urandom(), $urandom());
      end
      if (bus.rsp_valid != '0) begin
        res = bus.rsp_result; rv = bus.rsp_valid; lat = n - g_at + 1;
        break;
      end
    end
    chk("rsp_seen", lat > 0, 1);
    repeat (2) @(negedge clk);
  endtask

  int order [8];
  task automatic run_multi(input logic [N-1:0] mask, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int count, input logic [W-1:0] exp_res, output int got);
    got = 0;
    for (int k = 0; k < 8; k++) order[k] = -1;
    @(negedge clk);
    for (int k = 0; k < N; k++) if (mask[k]) set_op(k, a, b);
    bus.req = mask;
    for (int n = 0; n < 2000 && got < count; n++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) begin
        order[got] = idx_of(bus.rsp_valid);
        chk("multi_result", bus.rsp_result, exp_res);
        got++;
        if (got == count) bus.req = '0;
      end
    end
    bus.req = '0;
    repeat (60) @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] res;
    logic [N-1:0] rv;
    int lat, starts, gnts, got, rv_seen;
    int exp33 [5] = '{0, 1, 2, 3, 0};
    int exp34 [4] = '{0, 2, 0, 2};

    bus.req = '0; bus.req_a = '0; bus.req_b = '0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;

    run_single(0, 48, 18, 1'b0, res, rv, lat, starts, gnts);
    chk("r31_result", res, 6);
    chk("r31_rsp_valid", rv, 4'b0001);
    chk("r31_starts", starts, 1);
    chk("r31_gnts", gnts, 1);

    run_single(1, 0, 7, 1'b0, res, rv, lat, starts, gnts);
    chk("r32_result", res, 7);
    chk("r32_rsp_valid", rv, 4'b0010);
    chk("r32_latency", lat, 2);
    chk("r32_starts", starts, 0);
    run_single(1, 0, 0, 1'b0, res, rv, lat, starts, gnts);
    chk("r32_zero_result", res, 0);
    chk("r32_zero_latency", lat, 2);
    run_single(2, 9, 0, 1'b0, res, rv, lat, starts, gnts);
    chk("r32_bzero_result", res, 9);
    chk("r32_bzero_starts", starts, 0);

    run_single(3, 32'hFFFF_FFFF, 1, 1'b1, res, rv, lat, starts, gnts);
    chk("r36_result", res, 1);
    chk("r36_rsp_valid", rv, 4'b1000);
    chk("r36_starts", starts, 1);

    pulse_reset();
    run_multi(4'b1111, 12, 8, 5, 4, got);
    chk("r33_count", got, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("r33_order%0d", k), order[k], exp33[k]);

    pulse_reset();
    run_multi(4'b0101, 30, 12, 4, 6, got);
    chk("r34_count", got, 4);
    for (int k = 0; k < 4; k++) chk($sformatf("r34_order%0d", k), order[k], exp34[k]);

    // Abort an operation while the engine is iterating
    @(negedge clk);
    set_op(0, 1000, 3);
    bus.req[0] = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.gnt[0]) break;
    end
    bus.req[0] = 1'b0;
    @(negedge clk);
    chk("r35_busy_in_wait", bus.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("r35_gnt", bus.gnt, 0);
    chk("r35_rsp_valid", bus.rsp_valid, 0);
    chk("r35_busy", bus.busy, 0);
    chk("r35_eng_start", bus.eng_start, 0);
    chk("r35_rsp_result", bus.rsp_result, 0);
    chk("r35_eng_a", bus.eng_a, 0);
    chk("r35_eng_b", bus.eng_b, 0);
    rv_seen = 0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.rsp_valid != '0) rv_seen++;
    end
    chk("r35_no_orphan_rsp", rv_seen, 0);
    run_multi(4'b1010, 1000, 3, 1, 1, got);
    chk("r35_after_count", got, 1);
    chk("r35_after_idx", order[0], 1);

    // Randomized requesters, with one asynchronous reset in the middle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (cyc == 1500) #2 rst = 1'b1;
      if (cyc == 1503) #2 rst = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (bus.req[i]) begin
          if (bus.gnt[i]) begin
            if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
            else set_op(i, rand_op(), rand_op());
          end
        end else if ($urandom_range(0, 3) == 0) begin
          set_op(i, rand_op(), rand_op());
          bus.req[i] = 1'b1;
        end else if ($urandom_range(0, 2) == 0) begin
          set_op(i, rand_op(), rand_op());
        end
      end
    end
    bus.req = '0;
    repeat (300) @(negedge clk);
    chk("rand_activity", n_rsp > 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
